// File: rtl/delay_line_mt_if.sv
// Sample stream, tap controls and status of the multi-tap delay engine.
// master drives samples and controls; slave (the engine) drives output and status.
interface delay_line_mt_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
);
  logic [DATA_W-1:0] din;
  logic              valid_in;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] delay1;
  logic [ADDR_W-1:0] delay2;
  logic [3:0]        att1;
  logic [3:0]        att2;
  logic [3:0]        fb_shift;
  logic              clr_ovr;
  logic [DATA_W-1:0] dout;
  logic              valid_out;
  logic              busy;
  logic              overrun;

  modport master (
    output din, valid_in, mode, delay1, delay2, att1, att2, fb_shift, clr_ovr,
    input  dout, valid_out, busy, overrun
  );

  modport slave (
    input  din, valid_in, mode, delay1, delay2, att1, att2, fb_shift, clr_ovr,
    output dout, valid_out, busy, overrun
  );
endinterface

// File: rtl/delay_line_mt.sv
// Two-tap delay/echo engine over one circular-buffer RAM with feedback and saturating mix.
// Latency 3 cycles valid_in->valid_out; no stall: valid_in while busy is dropped and flags overrun.
module delay_line_mt #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 13,
  parameter int MIN_GAP = 4
) (
  input logic            clk,
  input logic            rst,
  delay_line_mt_if.slave bus
);

  localparam int SUM_W = DATA_W + 2;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {3'b111, {(DATA_W-1){1'b0}}};

  // The write-before-next-read ordering relies on the pipeline draining between samples.
  generate
    if (MIN_GAP < 3) begin : g_gap_chk
      $error("delay_line_mt: MIN_GAP must cover the 3-stage pipeline");
    end
  endgenerate

  logic [DATA_W-1:0] ram [DEPTH];

  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] fill_cnt;

  // S1 state
  logic              s1_vld;
  logic [DATA_W-1:0] s1_x;
  logic [1:0]        s1_mode;
  logic [3:0]        s1_att1;
  logic [3:0]        s1_att2;
  logic [3:0]        s1_fb;
  logic [ADDR_W-1:0] s1_raddr1;
  logic [ADDR_W-1:0] s1_raddr2;
  logic [ADDR_W-1:0] s1_d1;
  logic [ADDR_W-1:0] s1_d2;

  // S2 state
  logic              s2_vld;
  logic [DATA_W-1:0] s2_x;
  logic [1:0]        s2_mode;
  logic [3:0]        s2_att1;
  logic [3:0]        s2_att2;
  logic [3:0]        s2_fb;
  logic              s2_hit1;
  logic              s2_hit2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // Outputs
  logic [DATA_W-1:0] dout_q;
  logic              valid_out_q;
  logic              overrun_q;

  logic              busy;
  logic              accept;
  logic [ADDR_W-1:0] d1_eff;
  logic [ADDR_W-1:0] d2_eff;

  assign busy   = s1_vld | s2_vld;
  assign accept = bus.valid_in & ~busy;
  // A zero delay would read the slot about to be written; treat it as one sample.
  assign d1_eff = (bus.delay1 == '0) ? ADDR_W'(1) : bus.delay1;
  assign d2_eff = (bus.delay2 == '0) ? ADDR_W'(1) : bus.delay2;

  // S3 mix datapath
  logic [DATA_W-1:0]        tap1;
  logic [DATA_W-1:0]        tap2;
  logic [3:0]               sh1;
  logic signed [SUM_W-1:0]  x_ext;
  logic signed [SUM_W-1:0]  tap1_ext;
  logic signed [SUM_W-1:0]  tap2_ext;
  logic signed [SUM_W-1:0]  t1;
  logic signed [SUM_W-1:0]  t2;
  logic signed [SUM_W-1:0]  sum;
  logic signed [SUM_W-1:0]  sat;
  logic [DATA_W-1:0]        y;
  logic [DATA_W-1:0]        wdata;

  always_comb begin
    tap1     = s2_hit1 ? rd1 : '0;
    tap2     = s2_hit2 ? rd2 : '0;
    sh1      = (s2_mode == 2'b11) ? s2_fb : s2_att1;
    x_ext    = {{2{s2_x[DATA_W-1]}}, s2_x};
    tap1_ext = {{2{tap1[DATA_W-1]}}, tap1};
    tap2_ext = {{2{tap2[DATA_W-1]}}, tap2};
    t1       = tap1_ext >>> sh1;
    t2       = tap2_ext >>> s2_att2;
    case (s2_mode)
      2'b00:   sum = x_ext;
      2'b01:   sum = x_ext + t1;
      2'b10:   sum = x_ext + t1 + t2;
      default: sum = x_ext + t1;
    endcase
    if (sum > SAT_MAX) begin
      sat = SAT_MAX;
    end else if (sum < SAT_MIN) begin
      sat = SAT_MIN;
    end else begin
      sat = sum;
    end
    y     = sat[DATA_W-1:0];
    wdata = (s2_mode == 2'b11) ? y : s2_x;
  end

  // Buffer RAM kept free of reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (s2_vld && !rst) begin
      ram[wp] <= wdata;
    end
    rd1 <= ram[s1_raddr1];
    rd2 <= ram[s1_raddr2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp          <= '0;
      fill_cnt    <= '0;
      s1_vld      <= 1'b0;
      s1_x        <= '0;
      s1_mode     <= '0;
      s1_att1     <= '0;
      s1_att2     <= '0;
      s1_fb       <= '0;
      s1_raddr1   <= '0;
      s1_raddr2   <= '0;
      s1_d1       <= '0;
      s1_d2       <= '0;
      s2_vld      <= 1'b0;
      s2_x        <= '0;
      s2_mode     <= '0;
      s2_att1     <= '0;
      s2_att2     <= '0;
      s2_fb       <= '0;
      s2_hit1     <= 1'b0;
      s2_hit2     <= 1'b0;
      dout_q      <= '0;
      valid_out_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_x      <= bus.din;
        s1_mode   <= bus.mode;
        s1_att1   <= bus.att1;
        s1_att2   <= bus.att2;
        s1_fb     <= bus.fb_shift;
        s1_raddr1 <= wp - d1_eff;
        s1_raddr2 <= wp - d2_eff;
        s1_d1     <= d1_eff;
        s1_d2     <= d2_eff;
      end

      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_x    <= s1_x;
        s2_mode <= s1_mode;
        s2_att1 <= s1_att1;
        s2_att2 <= s1_att2;
        s2_fb   <= s1_fb;
        // Slots not yet written since reset hold stale data and read as silence.
        s2_hit1 <= (fill_cnt >= s1_d1);
        s2_hit2 <= (fill_cnt >= s1_d2);
      end

      valid_out_q <= s2_vld;
      if (s2_vld) begin
        dout_q <= y;
        wp     <= wp + ADDR_W'(1);
        if (fill_cnt != {ADDR_W{1'b1}}) begin
          fill_cnt <= fill_cnt + ADDR_W'(1);
        end
      end

      if (bus.valid_in && busy) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_ovr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.valid_out = valid_out_q;
  assign bus.busy      = busy;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_delay_line_mt.sv
// Directed bench for delay_line_mt: echo, feedback, saturation, stale masking, overrun, reset abort.
module tb_delay_line_mt;
  localparam int DW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  delay_line_mt_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  delay_line_mt #(.DATA_W(DW), .ADDR_W(AW), .MIN_GAP(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic do_reset();
    bus.valid_in = 1'b0;
    bus.clr_ovr  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One sample with 4-cycle spacing; reports first valid_out latency and its dout.
  task automatic send(input logic signed [DW-1:0] x, output logic signed [DW-1:0] y,
                      output int lat, output int nvo);
    lat = 0;
    nvo = 0;
    y   = '0;
    bus.din      = x;
    bus.valid_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.valid_in = 1'b0;
      if (bus.valid_out) begin
        nvo++;
        if (lat == 0) begin
          lat = k;
          y   = bus.dout;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic signed [DW-1:0] y;
    int lat, nvo;
    do_reset();
    bus.mode = 2'b00;
    send(16'sd123, y, lat, nvo);
    checks++;
    if (y !== 16'sd123) begin errors++; $display("FAIL rst_pre dout=%0d expected=123", y); end
    do_reset();
    checks++;
    if (bus.dout !== 16'h0) begin errors++; $display("FAIL rst_dout got=%0d expected=0", bus.dout); end
    checks++;
    if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid_out got=%b expected=0", bus.valid_out); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b expected=0", bus.busy); end
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got=%b expected=0", bus.overrun); end
  endtask

  task automatic test_echo();
    logic signed [DW-1:0] y, exp;
    int lat, nvo;
    do_reset();
    bus.mode = 2'b01; bus.delay1 = AW'(3); bus.att1 = 4'd1;
    for (int i = 0; i < 40; i++) begin
      exp = (i == 0) ? 16'sd1000 : (i == 3) ? 16'sd500 : 16'sd0;
      send((i == 0) ? 16'sd1000 : 16'sd0, y, lat, nvo);
      checks++;
      if (y !== exp) begin errors++; $display("FAIL echo[%0d] dout=%0d expected=%0d", i, y, exp); end
      checks++;
      if (lat != 3 || nvo != 1) begin
        errors++; $display("FAIL echo_lat[%0d] latency=%0d pulses=%0d expected 3/1", i, lat, nvo);
      end
    end
  endtask

  task automatic test_feedback();
    logic signed [DW-1:0] y, exp;
    int lat, nvo;
    do_reset();
    bus.mode = 2'b11; bus.delay1 = AW'(2); bus.fb_shift = 4'd1;
    for (int i = 0; i < 26; i++) begin
      exp = (i % 2 == 0) ? DW'(1024 >> (i / 2)) : 16'sd0;
      send((i == 0) ? 16'sd1024 : 16'sd0, y, lat, nvo);
      checks++;
      if (y !== exp || lat != 3) begin
        errors++; $display("FAIL fb[%0d] dout=%0d lat=%0d expected=%0d lat 3", i, y, lat, exp);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [DW-1:0] y, exp;
    int lat, nvo;
    do_reset();
    bus.mode = 2'b10; bus.delay1 = AW'(1); bus.delay2 = AW'(2); bus.att1 = 4'd0; bus.att2 = 4'd0;
    for (int i = 0; i < 5; i++) begin
      exp = (i == 0) ? 16'sd30000 : 16'sd32767;
      send(16'sd30000, y, lat, nvo);
      checks++;
      if (y !== exp) begin errors++; $display("FAIL sat_pos[%0d] dout=%0d expected=%0d", i, y, exp); end
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp = (i == 0) ? -16'sd30000 : -16'sd32768;
      send(-16'sd30000, y, lat, nvo);
      checks++;
      if (y !== exp) begin errors++; $display("FAIL sat_neg[%0d] dout=%0d expected=%0d", i, y, exp); end
    end
  endtask

  task automatic test_stale_mask();
    logic signed [DW-1:0] y;
    int lat, nvo;
    do_reset();
    bus.mode = 2'b00;
    for (int i = 0; i < 16; i++) begin
      send(16'sh1234, y, lat, nvo);
      checks++;
      if (y !== 16'sh1234) begin errors++; $display("FAIL fill[%0d] dout=%h expected=1234", i, y); end
    end
    do_reset();
    bus.mode = 2'b01; bus.delay1 = AW'(10); bus.att1 = 4'd0;
    for (int i = 0; i < 8; i++) begin
      send(16'sd0, y, lat, nvo);
      checks++;
      if (y !== 16'sd0) begin errors++; $display("FAIL stale[%0d] dout=%h expected=0", i, y); end
    end
  endtask

  task automatic test_overrun();
    logic [DW-1:0] y;
    logic busy1;
    int nvo;
    do_reset();
    bus.mode = 2'b00;
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_init got=%b expected=0", bus.overrun); end
    nvo = 0; y = '0; busy1 = 1'b0;
    bus.din = 16'd11; bus.valid_in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.valid_in = 1'b0; busy1 = bus.busy; end
      if (k == 2) begin bus.din = 16'd22; bus.valid_in = 1'b1; end
      if (k == 3) bus.valid_in = 1'b0;
      if (bus.valid_out) begin nvo++; y = bus.dout; end
    end
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL ovr_busy got=%b expected=1", busy1); end
    checks++;
    if (nvo != 1) begin errors++; $display("FAIL ovr_pulses got=%0d expected=1", nvo); end
    checks++;
    if (y !== 16'd11) begin errors++; $display("FAIL ovr_dout got=%0d expected=11", y); end
    checks++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got=%b expected=1", bus.overrun); end
    bus.clr_ovr = 1'b1;
    @(negedge clk);
    bus.clr_ovr = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b expected=0", bus.overrun); end
  endtask

  task automatic test_rst_abort();
    logic signed [DW-1:0] y;
    int lat, nvo, vo;
    do_reset();
    bus.mode = 2'b00;
    send(16'sd777, y, lat, nvo);
    checks++;
    if (y !== 16'sd777) begin errors++; $display("FAIL abort_pre dout=%0d expected=777", y); end
    bus.din = 16'sd500; bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.dout !== 16'h0) begin errors++; $display("FAIL abort_dout got=%0d expected=0", bus.dout); end
    vo = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.valid_out) vo++;
      @(negedge clk);
    end
    checks++;
    if (vo != 0) begin errors++; $display("FAIL abort_valid pulses=%0d expected=0", vo); end
    bus.mode = 2'b01; bus.delay1 = '0; bus.att1 = 4'd0;
    send(16'sd100, y, lat, nvo);
    checks++;
    if (y !== 16'sd100) begin errors++; $display("FAIL d0_a dout=%0d expected=100", y); end
    send(16'sd200, y, lat, nvo);
    checks++;
    if (y !== 16'sd300) begin errors++; $display("FAIL d0_b dout=%0d expected=300", y); end
    send(16'sd0, y, lat, nvo);
    checks++;
    if (y !== 16'sd200) begin errors++; $display("FAIL d0_c dout=%0d expected=200", y); end
  endtask

  initial begin
    bus.din = '0; bus.valid_in = 1'b0; bus.mode = 2'b00;
    bus.delay1 = '0; bus.delay2 = '0; bus.att1 = '0; bus.att2 = '0;
    bus.fb_shift = '0; bus.clr_ovr = 1'b0;
    @(negedge clk);
    test_reset();
    test_echo();
    test_feedback();
    test_saturation();
    test_stale_mask();
    test_overrun();
    test_rst_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
